// File: rtl/ieee754_pkg.sv
// Shared binary32 field layout and constants for the fixed-point converter and IEEE754_Adder.
package ieee754_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_W    = 8;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float32_t;

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module lzc #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CntW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CntW-1:0]  o_count
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_count = CntW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CntW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fixed_to_ieee754.sv
// 3-stage signed fixed-point to binary32 converter with valid/ready backpressure.
// Define FIXED_TO_IEEE754_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fixed_to_ieee754
  import ieee754_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 18
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data
);

  localparam int unsigned LzW     = $clog2(WIDTH + 1);
  localparam int unsigned ExtW    = (WIDTH < 25) ? 25 : WIDTH;
  localparam logic [8:0]  ExpBase = 9'(EXP_BIAS + WIDTH - 1 - FRAC_BITS);

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [WIDTH-1:0] r_s1_mag;
  logic             r_s2_valid;
  logic             r_s2_sign;
  logic             r_s2_zero;
  logic [WIDTH-1:0] r_s2_norm;
  logic [8:0]       r_s2_exp;
  logic             r_out_valid;
  logic [31:0]      r_out_data;

  logic             w_advance;
  logic [WIDTH-1:0] w_in_mag;
  logic [LzW-1:0]   w_lz;
  logic [ExtW-1:0]  w_ext;
  logic [22:0]      w_mant_t;
  logic [22:0]      w_mant;
  logic [8:0]       w_exp;
  logic             w_unused;
  float32_t         w_s3_result;

  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Negating the most negative input wraps to exactly 2^(WIDTH-1) as an unsigned magnitude.
  assign w_in_mag = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;

  lzc #(
    .WIDTH (WIDTH)
  ) u_lzc (
    .i_data  (r_s1_mag),
    .o_count (w_lz)
  );

  // Left-align the normalised value so the 23 mantissa bits sit just below the hidden one.
  assign w_ext    = ExtW'(r_s2_norm) << (ExtW - WIDTH);
  assign w_mant_t = w_ext[ExtW-2 -: 23];

`ifdef FIXED_TO_IEEE754_RNE_EN
  localparam logic [ExtW-1:0] StickyMask = ExtW'((64'd1 << (ExtW - 25)) - 64'd1);

  logic w_guard;
  logic w_sticky;
  logic w_round_up;
  logic w_carry;

  assign w_guard    = w_ext[ExtW-25];
  assign w_sticky   = |(w_ext & StickyMask);
  assign w_round_up = w_guard && (w_sticky || w_mant_t[0]);
  assign {w_carry, w_mant} = {1'b0, w_mant_t} + 24'(w_round_up);
  assign w_exp      = r_s2_exp + 9'(w_carry);
  assign w_unused   = ^{w_ext[ExtW-1], w_exp[8]};
`else
  assign w_mant   = w_mant_t;
  assign w_exp    = r_s2_exp;
  assign w_unused = ^{w_ext[ExtW-1], w_exp[8], w_ext[ExtW-25:0]};
`endif

  always_comb begin
    w_s3_result = '0;
    if (!r_s2_zero) begin
      w_s3_result.sign = r_s2_sign;
      w_s3_result.exp  = w_exp[7:0];
      w_s3_result.mant = w_mant;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_mag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_zero   <= 1'b1;
      r_s2_norm   <= '0;
      r_s2_exp    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= in_valid;
      r_s1_sign   <= in_data[WIDTH-1];
      r_s1_mag    <= w_in_mag;
      r_s2_valid  <= r_s1_valid;
      r_s2_sign   <= r_s1_sign;
      r_s2_zero   <= (r_s1_mag == '0);
      r_s2_norm   <= r_s1_mag << w_lz;
      r_s2_exp    <= ExpBase - 9'(w_lz);
      r_out_valid <= r_s2_valid;
      r_out_data  <= w_s3_result;
    end
  end

endmodule

// File: tb/tb_fixed_to_ieee754.sv
// Self-checking bench: directed vectors, backpressure, async reset flush and random streams
// on two converter instances (FRAC_BITS=18 and FRAC_BITS=0) sharing one input port.
module tb_fixed_to_ieee754;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        in_ready18, out_valid18, in_ready0, out_valid0;
  logic [31:0] out_data18, out_data0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_in[$];
  logic [31:0] q_e18[$];
  logic [31:0] q_e0[$];

  typedef struct {
    logic [31:0] din;
    logic [31:0] e18;
    logic [31:0] e0;
  } vec_t;
  vec_t vecs[9];

  always #5 clock = ~clock;

  fixed_to_ieee754 #(.WIDTH(32), .FRAC_BITS(18)) u_dut18 (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready18),
    .in_data   (in_data),
    .out_valid (out_valid18),
    .out_ready (out_ready),
    .out_data  (out_data18)
  );

  fixed_to_ieee754 #(.WIDTH(32), .FRAC_BITS(0)) u_dut0 (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value = din / 2^frac, rounded to a 24-bit significand by plain integer arithmetic.
  function automatic logic [31:0] model(input logic [31:0] din, input int frac);
    logic [63:0] mag, q;
    logic        sgn;
    int          p, e;
`ifdef FIXED_TO_IEEE754_RNE_EN
    logic [63:0] rem, half;
`endif
    sgn = din[31];
    mag = sgn ? 64'(-longint'(signed'(din))) : 64'(din);
    if (mag == 64'd0) return 32'h0;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    e = 127 + p - frac;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      q = mag >> (p - 23);
`ifdef FIXED_TO_IEEE754_RNE_EN
      rem  = mag - (q << (p - 23));
      half = 64'd1 << (p - 24);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
`endif
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {sgn, e[7:0], q[22:0]};
  endfunction

  task automatic apply_one(input vec_t v);
    int lat;
    @(posedge clock); #1;
    in_valid  = 1'b1;
    in_data   = v.din;
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid18 && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    chk($sformatf("latency[%h]", v.din), 32'(lat), 32'd3);
    chk($sformatf("f18[%h]", v.din), out_data18, v.e18);
    chk($sformatf("f0[%h]", v.din), out_data0, v.e0);
    chk($sformatf("valid0[%h]", v.din), 32'(out_valid0), 32'd1);
  endtask

  // mode 0: continuous input, out_ready low for cycles 5..8. mode 1: random valid/ready.
  task automatic run_stream(input int mode, input int budget, output int stalls);
    int          total, got;
    logic        prev_stall;
    logic [31:0] prev18, prev0, e18, e0;
    total = q_in.size();
    got = 0;
    stalls = 0;
    prev_stall = 1'b0;
    prev18 = '0;
    prev0 = '0;
    for (int cyc = 0; cyc < budget && got < total; cyc++) begin
      @(posedge clock); #1;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid18), 32'd1);
        chk("stall_data18", out_data18, prev18);
        chk("stall_data0", out_data0, prev0);
      end
      if (mode == 0) out_ready = !(cyc >= 5 && cyc < 9);
      else           out_ready = ($urandom % 4) != 0;
      in_valid = (q_in.size() > 0) && (mode == 0 || ($urandom % 3) != 0);
      in_data  = (q_in.size() > 0) ? q_in[0] : 32'h0;
      #1;
      chk("in_ready18", 32'(in_ready18), 32'(!out_valid18 || out_ready));
      chk("in_ready0", 32'(in_ready0), 32'(!out_valid0 || out_ready));
      if (in_valid && in_ready18) void'(q_in.pop_front());
      if (out_valid18 && out_ready) begin
        if (q_e18.size() == 0) begin
          chk("extra_output", 32'd1, 32'd0);
        end else begin
          e18 = q_e18.pop_front();
          e0  = q_e0.pop_front();
          chk("stream_f18", out_data18, e18);
          chk("stream_f0", out_data0, e0);
          chk("stream_valid0", 32'(out_valid0), 32'd1);
          got++;
        end
      end
      if (out_valid18 && !out_ready) stalls++;
      prev_stall = out_valid18 && !out_ready;
      prev18 = out_data18;
      prev0  = out_data0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 32'(got), 32'(total));
    q_in.delete();
    q_e18.delete();
    q_e0.delete();
  endtask

  initial begin
    int          stalls;
    logic [31:0] r;

    vecs[0] = '{32'h0004_0000, 32'h3F80_0000, 32'h4880_0000};
    vecs[1] = '{32'hFFFC_0000, 32'hBF80_0000, 32'hC880_0000};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{32'h8000_0000, 32'hC600_0000, 32'hCF00_0000};
    vecs[4] = '{32'h0100_0001, 32'h4280_0000, 32'h4B80_0000};
    vecs[5] = '{32'h0000_0001, 32'h3680_0000, 32'h3F80_0000};
    vecs[6] = '{32'hFFFF_FFFF, 32'hB680_0000, 32'hBF80_0000};
`ifdef FIXED_TO_IEEE754_RNE_EN
    vecs[7] = '{32'h7FFF_FFFF, 32'h4600_0000, 32'h4F00_0000};
    vecs[8] = '{32'h0100_0003, 32'h4280_0002, 32'h4B80_0002};
`else
    vecs[7] = '{32'h7FFF_FFFF, 32'h45FF_FFFF, 32'h4EFF_FFFF};
    vecs[8] = '{32'h0100_0003, 32'h4280_0001, 32'h4B80_0001};
`endif

    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    chk("reset_valid", 32'(out_valid18), 32'd0);
    chk("reset_data", out_data18, 32'h0);
    chk("reset_data0", out_data0, 32'h0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready18), 32'd1);

    foreach (vecs[i]) apply_one(vecs[i]);

    for (int i = 0; i < 8; i++) begin
      r = 32'h0123_4567 * (i + 1) ^ (32'h8000_0000 * (i % 2));
      q_in.push_back(r);
      q_e18.push_back(model(r, 18));
      q_e0.push_back(model(r, 0));
    end
    run_stream(0, 100, stalls);
    chk("backpressure_stalls", 32'(stalls), 32'd4);

    @(posedge clock); #1;
    in_valid = 1'b1;
    in_data  = 32'h0004_0000;
    @(posedge clock); #1;
    in_data = 32'h0008_0000;
    @(posedge clock); #1;
    in_data = 32'h000C_0000;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("flush_pre_valid", 32'(out_valid18), 32'd1);
    resetn = 1'b0;
    #1;
    chk("flush_valid", 32'(out_valid18), 32'd0);
    chk("flush_data", out_data18, 32'h0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      chk("flush_no_stale", 32'(out_valid18 | out_valid0), 32'd0);
    end

    for (int k = 0; k < 2000; k++) begin
      r = $urandom;
      if (k % 3 == 0) r = 32'($signed(r) >>> $urandom_range(1, 30));
      q_in.push_back(r);
      q_e18.push_back(model(r, 18));
      q_e0.push_back(model(r, 0));
    end
    run_stream(1, 20000, stalls);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
